// File: rtl/axis_c_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : axis_c_result_collector
// Purpose  : Sink for the accelerator C result stream. After a legal arm it
//            accepts cfg_len beats into an internal buffer and checks that
//            tlast coincides with the final beat. The buffer stays readable
//            through a registered random-access read port in every state.
// Revision : 1.0 - initial release
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   arm, cfg_len        start pulse and expected beat count (sampled on arm)
//   s_axis_c_*          AXI4-Stream slave (tvalid/tready/tdata/tlast)
//   rd_en, rd_addr      buffer read request and word address
//   rd_data, rd_valid   read data, one cycle after rd_en
//   busy, done          state indicators (COLLECT, DONE)
//   beat_cnt            beats accepted in the current/last run
//   err_cfg             sticky: arm with cfg_len of 0 or above DEPTH
//   err_early_last      sticky: tlast before the final beat
//   err_missing_last    sticky: final beat without tlast
//   checksum            (COLLECTOR_CHECKSUM_EN only) running sum of tdata
//
// Build option
//   COLLECTOR_CHECKSUM_EN : when defined, adds the checksum output.
// ============================================================================
module axis_c_result_collector #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              s_axis_c_tvalid,
  output logic              s_axis_c_tready,
  input  logic [DATA_W-1:0] s_axis_c_tdata,
  input  logic              s_axis_c_tlast,
  input  logic              rd_en,
  // One bit wider than the buffer index so out-of-range reads are visible.
  input  logic [CNT_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              err_cfg,
  output logic              err_early_last,
`ifdef COLLECTOR_CHECKSUM_EN
  output logic              err_missing_last,
  output logic [DATA_W-1:0] checksum
`else
  output logic              err_missing_last
`endif
);

  localparam int              AW      = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  last_idx;   // cfg_len - 1, index of the final beat
  logic [DATA_W-1:0] mem [DEPTH];

  logic handshake;
  logic cfg_ok;
  logic is_final;

  assign handshake = s_axis_c_tvalid && s_axis_c_tready;
  assign cfg_ok    = (cfg_len != '0) && (cfg_len <= DEPTH_C);
  assign is_final  = (beat_cnt == last_idx);

  // --------------------------------------------------------------------------
  // Control FSM. tready/busy/done are registered and updated together with
  // the state, so tready drops on the same edge that leaves COLLECT.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      last_idx         <= '0;
      beat_cnt         <= '0;
      s_axis_c_tready  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_cfg          <= 1'b0;
      err_early_last   <= 1'b0;
      err_missing_last <= 1'b0;
`ifdef COLLECTOR_CHECKSUM_EN
      checksum         <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            if (cfg_ok) begin
              state            <= S_COLLECT;
              last_idx         <= cfg_len - ONE_C;
              beat_cnt         <= '0;
              s_axis_c_tready  <= 1'b1;
              busy             <= 1'b1;
              done             <= 1'b0;
              err_cfg          <= 1'b0;
              err_early_last   <= 1'b0;
              err_missing_last <= 1'b0;
`ifdef COLLECTOR_CHECKSUM_EN
              checksum         <= '0;
`endif
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end

        S_COLLECT: begin
          if (handshake) begin
            beat_cnt <= beat_cnt + ONE_C;
`ifdef COLLECTOR_CHECKSUM_EN
            checksum <= checksum + s_axis_c_tdata;
`endif
            // Either the final beat or an early tlast terminates the run.
            if (is_final || s_axis_c_tlast) begin
              state           <= S_DONE;
              s_axis_c_tready <= 1'b0;
              busy            <= 1'b0;
              done            <= 1'b1;
              if (is_final && !s_axis_c_tlast) err_missing_last <= 1'b1;
              if (!is_final)                   err_early_last   <= 1'b1;
            end
          end
        end

        default: begin
          state           <= S_IDLE;
          s_axis_c_tready <= 1'b0;
          busy            <= 1'b0;
          done            <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Buffer write. Kept free of reset so it maps onto RAM primitives.
  // beat_cnt stays below DEPTH while tready is high, so the index is in range.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (handshake) begin
      mem[beat_cnt[AW-1:0]] <= s_axis_c_tdata;
    end
  end

  // --------------------------------------------------------------------------
  // Registered read port. A same-cycle write to the read address returns the
  // previous contents (read-before-write).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= (rd_addr < DEPTH_C) ? mem[rd_addr[AW-1:0]] : '0;
      end
    end
  end

endmodule
`default_nettype wire
